// File: rtl/chess_pkg.sv
// Shared widths, slot encoding and controller state type for the move packing FIFO.
// A packed word holds eight 19-bit slots; the top bit of each slot marks it empty.
package chess_pkg;

    localparam int MOVE_W = 18;
    localparam int SLOT_W = 19;
    localparam int SLOTS  = 8;
    localparam int WORD_W = 152;

    // Every slot empty: invalid flag set, move bits cleared.
    localparam logic [WORD_W-1:0] ALL_INVALID = {SLOTS{{1'b1, {MOVE_W{1'b0}}}}};

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

endpackage

// File: rtl/move_fifo_mem.sv
// Packed-word storage: synchronous write, registered read, no reset on the array
// so it maps onto block RAM.
module move_fifo_mem
    import chess_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/move_pack_fifo.sv
// Packs 18-bit move codes eight to a word and queues the words for a consumer;
// gen_end flushes any partial word and latches done until the next reset.
module move_pack_fifo
    import chess_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MOVE_W-1:0]          move_in,
    input  logic                       move_valid,
    input  logic                       gen_end,
    output logic                       move_ready,
    input  logic                       rden,
    output logic [WORD_W-1:0]          fifoOut,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     word_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [2:0]        pack_count_q, pack_count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              out_sel_q, out_sel_d;

    logic              mv_acc;
    logic              gen_acc;
    logic              push;
    logic              pop_mem;
    logic [WORD_W-1:0] pack_with;
    logic [WORD_W-1:0] mem_rd_data;

    assign move_ready = (state_q == ST_COLLECT) && (count_q < CW'(DEPTH));
    assign mv_acc     = move_valid && move_ready;
    assign gen_acc    = gen_end && move_ready;

    // Pack register with this cycle's accepted move dropped into the next free slot.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign pack_with[gi*SLOT_W +: SLOT_W] =
                (mv_acc && (pack_count_q == 3'(gi))) ? {1'b0, move_in}
                                                     : pack_q[gi*SLOT_W +: SLOT_W];
        end
    endgenerate

    assign push    = (mv_acc && (pack_count_q == 3'd7)) ||
                     (gen_acc && (mv_acc || (pack_count_q != 3'd0)));
    assign pop_mem = rden && (count_q != '0);

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        pack_d       = pack_q;
        pack_count_d = pack_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_sel_d    = out_sel_q;

        if (push) begin
            pack_d       = ALL_INVALID;
            pack_count_d = 3'd0;
            wr_ptr_d     = wr_ptr_q + AW'(1);
        end else if (mv_acc) begin
            pack_d       = pack_with;
            pack_count_d = pack_count_q + 3'd1;
        end

        if (pop_mem) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // An empty pop presents ALL_INVALID instead of stale RAM data.
        if (rden) begin
            out_sel_d = pop_mem;
        end

        count_d = count_q + CW'(push) - CW'(pop_mem);

        if (gen_acc) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_COLLECT;
            done_q       <= 1'b0;
            pack_q       <= ALL_INVALID;
            pack_count_q <= 3'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pack_q       <= pack_d;
            pack_count_q <= pack_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_sel_q    <= out_sel_d;
        end
    end

    move_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (pack_with),
        .rd_en   (pop_mem),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    assign fifoOut    = out_sel_q ? mem_rd_data : ALL_INVALID;
    assign done       = done_q;
    assign word_count = count_q;

endmodule

// File: doc/move_pack_fifo.md
MOVE_PACK_FIFO -- requirements
Module: move_pack_fifo

Interface
REQ-001 Parameter DEPTH, 16: number of 152-bit packed words stored; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high; also acts as "start new generation".
REQ-004 move_in  input  18  opaque move code from the generator.
REQ-005 move_valid  input  1  move_in is offered this cycle.
REQ-006 gen_end  input  1  generator has finished; no further moves this generation.
REQ-007 move_ready  output  1  move_valid and gen_end are accepted this cycle when high.
REQ-008 rden  input  1  consumer pops one packed word.
REQ-009 fifoOut  output  152  packed word, 8 slots of 19 bits.
REQ-010 done  output  1  generation complete and all moves flushed into storage.
REQ-011 word_count  output  $clog2(DEPTH)+1  number of packed words currently stored.

Function
REQ-012 Slot k (0..7) SHALL occupy fifoOut[19k+18:19k]; bit 19k+18 is the invalid flag (1 = empty slot); bits [19k+17:19k] hold the move.
REQ-013 An empty slot SHALL be encoded as invalid flag 1 with move bits 0; the all-invalid word (ALL_INVALID) has every flag set and every move bit 0.
REQ-014 A pack register SHALL fill slots in order 0..7 with accepted moves; pack_count tracks filled slots (0..7).
REQ-015 A move is accepted when move_valid=1 and move_ready=1.
REQ-016 move_ready SHALL equal (state==COLLECT) and (word_count < DEPTH); it is combinational from registered state.
REQ-017 When an accepted move fills slot 7, the completed word SHALL be pushed into storage on that edge and pack_count SHALL return to 0.
REQ-018 gen_end is accepted only when move_ready=1; the producer SHALL hold gen_end until accepted.
REQ-019 On accepted gen_end with a non-empty pack register, the partial word SHALL be pushed with unfilled slots set to empty; a move accepted on the same cycle is included first.
REQ-020 Accepted gen_end with pack_count=0 and no same-cycle move SHALL push nothing.
REQ-021 States: COLLECT (after reset) -> DONE on accepted gen_end; DONE -> COLLECT only via reset.
REQ-022 done SHALL be 1 exactly in state DONE, i.e. from the cycle after gen_end is accepted.
REQ-023 rden sampled high on edge N SHALL pop the oldest word into fifoOut, valid from cycle N+1 and held until the next pop.
REQ-024 rden with word_count=0 SHALL load ALL_INVALID into fifoOut; word_count stays 0.
REQ-025 Simultaneous push and pop SHALL both occur; word_count unchanged; a pop from an empty store never returns the word being pushed that cycle.
REQ-026 rden is legal in any state; consumers read only after done=1.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; word_count uses one extra bit to distinguish full from empty.

Reset
REQ-028 On reset: state=COLLECT, pack_count=0, pointers=0, word_count=0, done=0, fifoOut=ALL_INVALID, pack register cleared to empty slots.
REQ-029 Reset mid-generation or mid-read SHALL discard all stored and partial words; inputs that cycle are ignored.

Structure
REQ-030 Shared package chess_pkg SHALL hold MOVE_W=18, SLOT_W=19, SLOTS=8, WORD_W=152 and ALL_INVALID.
REQ-031 Word storage SHALL be a sub-module move_fifo_mem (DEPTH x WORD_W, synchronous write, registered read) inferable as block RAM.

Verification
REQ-032 Reset, 3 moves 18'h00001..18'h00003, gen_end -> done next cycle; rden -> fifoOut slots 0-2 = those moves with flag 0, slots 3-7 = flag 1, move 0; second rden -> ALL_INVALID.
REQ-033 Reset, gen_end only -> done=1, word_count=0; rden -> ALL_INVALID.
REQ-034 Exactly 8 moves then gen_end -> word_count=1 (no extra partial word); 9 moves then gen_end -> word_count=2, second word has only slot 0 valid.
REQ-035 DEPTH=16, 128 moves without reads -> move_ready=0 once word_count=16; rden then restores move_ready=1 next cycle; no move lost or duplicated.
REQ-036 Push and pop on the same edge at word_count=5 -> word_count stays 5, popped word is the oldest.
REQ-037 Reset asserted after 20 moves -> word_count=0, done=0, fifoOut=ALL_INVALID; new generation of 2 moves reads back correctly.
